// File: rtl/audio_pkg.sv
// Shared audio-path types: sample type, output handshake state and a saturating narrow helper.
package audio_pkg;

  localparam int unsigned DEFAULT_SAMPLE_W = 16;

  typedef logic signed [DEFAULT_SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Clamp a wide signed value to the signed range of a w-bit result; caller truncates to w bits.
  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/adc_sample_decimator_if.sv
// Result handshake from the decimator to the effects chain.
interface adc_sample_decimator_if #(
  parameter int unsigned SAMPLE_W = audio_pkg::DEFAULT_SAMPLE_W
);
  logic signed [SAMPLE_W-1:0] o_sample;
  logic                       o_valid;
  logic                       i_ready;

  modport master (output o_sample, output o_valid, input  i_ready);
  modport slave  (input  o_sample, input  o_valid, output i_ready);
endinterface

// File: rtl/adc_dc_blocker.sv
// DC offset removal on decimated results: leaky estimator, subtract, saturate, one register stage.
// Only instantiated when ADC_DC_BLOCK_EN is defined.
module adc_dc_blocker
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W,
  parameter int unsigned DC_SHIFT = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] i_avg,
  input  logic                       i_avg_valid,
  output logic signed [SAMPLE_W-1:0] o_res,
  output logic                       o_res_valid
);

  localparam int unsigned EST_W  = SAMPLE_W + DC_SHIFT + 1;
  localparam int unsigned DIFF_W = EST_W + 1;

  logic signed [EST_W-1:0]  est;
  logic signed [EST_W-1:0]  est_sh_c;
  logic signed [DIFF_W-1:0] diff_c;

  assign est_sh_c = est >>> DC_SHIFT;
  assign diff_c   = DIFF_W'(i_avg) - DIFF_W'(est_sh_c);

  // Estimate advances on every result, even one the output stage later drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      est         <= '0;
      o_res       <= '0;
      o_res_valid <= 1'b0;
    end else begin
      o_res_valid <= i_avg_valid;
      if (i_avg_valid) begin
        est   <= est + EST_W'(i_avg) - est_sh_c;
        o_res <= SAMPLE_W'(sat_narrow(64'(diff_c), SAMPLE_W));
      end
    end
  end

endmodule

// File: rtl/adc_sample_decimator.sv
// Boxcar decimator: averages 2^LOG2_DECIM samples and offers each result on a valid/ready port
// with a sticky overrun flag. Define ADC_DC_BLOCK_EN to add DC removal (one extra cycle latency).
module adc_sample_decimator
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned DC_SHIFT   = 10
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic signed [SAMPLE_W-1:0]                      i_sample,
  input  logic                                            i_sample_valid,
  adc_sample_decimator_if.master                          res,
  output logic                                            o_overrun,
  input  logic                                            i_clear_overrun,
  output logic [((LOG2_DECIM > 0) ? LOG2_DECIM : 1)-1:0]  o_phase
);

  localparam int unsigned ACC_W = SAMPLE_W + LOG2_DECIM;
  localparam int unsigned PH_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'((1 << LOG2_DECIM) - 1);

  if (DC_SHIFT == 0 || SAMPLE_W + DC_SHIFT + 2 > 64) begin : g_bad_dc_shift
    $error("adc_sample_decimator: DC_SHIFT out of range");
  end

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_sum_c;
  logic signed [SAMPLE_W-1:0] avg_c;
  logic                       win_done_c;
  logic signed [SAMPLE_W-1:0] res_data;
  logic                       res_valid;
  logic                       drop_c;
  out_state_t                 state;

  assign acc_sum_c  = acc + ACC_W'(i_sample);
  assign win_done_c = i_sample_valid && (o_phase == LAST_PHASE);
  assign avg_c      = SAMPLE_W'(acc_sum_c >>> LOG2_DECIM);

  // Window accumulator; with LOG2_DECIM=0 every sample closes a window so phase stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      o_phase <= '0;
    end else if (i_sample_valid) begin
      if (win_done_c) begin
        acc     <= '0;
        o_phase <= '0;
      end else begin
        acc     <= acc_sum_c;
        o_phase <= o_phase + PH_W'(1);
      end
    end
  end

`ifdef ADC_DC_BLOCK_EN
  adc_dc_blocker #(
    .SAMPLE_W (SAMPLE_W),
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk         (clk),
    .rst         (rst),
    .i_avg       (avg_c),
    .i_avg_valid (win_done_c),
    .o_res       (res_data),
    .o_res_valid (res_valid)
  );
`else
  assign res_data  = avg_c;
  assign res_valid = win_done_c;
`endif

  assign drop_c = (state == FULL) && !res.i_ready && res_valid;

  // Output holding register; a result arriving while the held one is still pending is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      res.o_sample <= '0;
      res.o_valid  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_overrun <= drop_c | (o_overrun & ~i_clear_overrun);
      case (state)
        EMPTY: begin
          if (res_valid) begin
            res.o_sample <= res_data;
            res.o_valid  <= 1'b1;
            state        <= FULL;
          end
        end
        FULL: begin
          if (res.i_ready) begin
            if (res_valid) begin
              res.o_sample <= res_data;
            end else begin
              res.o_valid <= 1'b0;
              state       <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
